// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter: round-robin front end that time-shares one iterative
// sqrt core among NUM_REQ operand producers. Each accepted operand is
// issued to the core, the result is held on a backpressured response port
// and tagged with the requester index. Zero operands bypass the core.
// Optional: define SQRT_WDOG_EN to add a WAIT-state watchdog that forces an
// all-ones result with rsp_err=1 after TIMEOUT cycles without sqrt_ready.
module sqrt_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      sqrt_start,
  output logic [DATA_W-1:0]         sqrt_input,
  input  logic [DATA_W-1:0]         sqrt_out,
  input  logic                      sqrt_ready,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready,
  output logic                      rsp_err,
  output logic                      busy
);

  // Reject configurations the ID field cannot represent.
  if (NUM_REQ < 2 || (1 << ID_W) < NUM_REQ) begin : g_bad_cfg
    $error("sqrt_share_arbiter: need NUM_REQ>=2 and 2**ID_W >= NUM_REQ");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sqrt_share_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

`ifdef SQRT_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  logic                gnt_any;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     gnt_nxt;
  logic [DATA_W-1:0]   gnt_data;

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    int idx;
    logic [NUM_REQ-1:0] vshift;
    gnt_any  = 1'b0;
    gnt_oh   = '0;
    gnt_idx  = '0;
    gnt_nxt  = '0;
    gnt_data = '0;
    idx      = 0;
    vshift   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      vshift = req_valid >> idx;
      if (!gnt_any && vshift[0]) begin
        gnt_any  = 1'b1;
        gnt_oh   = NUM_REQ'(1) << idx;
        gnt_idx  = ID_W'(idx);
        gnt_nxt  = (idx + 1 >= NUM_REQ) ? '0 : ID_W'(idx + 1);
        gnt_data = DATA_W'(req_data >> (idx * DATA_W));
      end
    end
  end

  // Next-state logic: accept in IDLE, pulse start in ISSUE, capture in WAIT,
  // hold the response until the downstream takes it.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
`ifdef SQRT_WDOG_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_d     = gnt_data;
          id_d     = gnt_idx;
          rr_ptr_d = gnt_nxt;
`ifdef SQRT_WDOG_EN
          rsp_err_d = 1'b0;
`endif
          if (gnt_data == '0) begin
            // sqrt(0)=0: skip the core entirely
            rsp_data_d = '0;
            state_d    = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // any sqrt_ready here belongs to nothing we issued; ignore it
        state_d = WAIT;
`ifdef SQRT_WDOG_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        if (sqrt_ready) begin
          rsp_data_d = sqrt_out;
          state_d    = HOLD;
`ifdef SQRT_WDOG_EN
          rsp_err_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
`ifdef SQRT_WDOG_EN
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
`ifdef SQRT_WDOG_EN
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // Output decode; req_ready is suppressed while reset is asserted.
  always_comb begin
    req_ready  = (state_q == IDLE && rst_n) ? gnt_oh : '0;
    sqrt_start = (state_q == ISSUE);
    sqrt_input = op_q;
    rsp_valid  = (state_q == HOLD);
    rsp_data   = rsp_data_q;
    rsp_id     = id_q;
    busy       = (state_q != IDLE);
`ifdef SQRT_WDOG_EN
    rsp_err    = rsp_err_q;
`else
    rsp_err    = 1'b0;
`endif
  end

endmodule
